// File: rtl/tpu_dma_pkg.sv
// Shared definitions for the DMA read/write engines around the shared BRAM.
// Holds the read FSM state type, BRAM timing constants and buffer occupancy helper.
package tpu_dma_pkg;

  localparam int BRAM_RD_LATENCY = 1;
  localparam int DMA_PTR_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  // True when one more read can be issued without overrunning the 2-entry buffer.
  function automatic logic has_room(input logic [1:0] count,
                                    input logic       inflight,
                                    input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight};
    if (pop) begin
      has_room = (occ <= 3'd2);
    end else begin
      has_room = (occ <= 3'd1);
    end
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output buffer between the BRAM read path and the stream port.
// The head entry is presented combinationally from registered storage.
module stream_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_idx_r;
  logic             rd_idx_r;
  logic [1:0]       count_r;

  // Storage, ring indices and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_idx_r <= 1'b0;
      rd_idx_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (clr) begin
      wr_idx_r <= 1'b0;
      rd_idx_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_idx_r] <= push_data;
        wr_idx_r        <= ~wr_idx_r;
      end
      if (pop) begin
        rd_idx_r <= ~rd_idx_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_idx_r];
  assign count = count_r;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side DMA engine: drains length words from BRAM port A onto an AXI-Stream
// master, absorbing the 1-cycle read latency and backpressure in a 2-entry buffer.
module bram_stream_reader
  import tpu_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     length,
  input  logic                     wr_busy,
  output logic                     busy,
  output logic                     done,
  output logic                     dma_rd_en,
  output logic [DMA_PTR_WIDTH-1:0] dma_read_pointer,
  input  logic [DATA_WIDTH-1:0]    dma_rd_data,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast
);

  rd_state_t            state_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] issue_cnt_r;
  logic [LEN_WIDTH-1:0] inflight_ptr_r;
  logic                 inflight_r;

  logic                 rd_en_s;
  logic                 pop_s;
  logic                 fifo_clr_s;
  logic                 push_last_s;
  logic [DATA_WIDTH:0]  head_s;
  logic [1:0]           count_s;

  assign m_axis_tvalid = (count_s != 2'd0);
  assign m_axis_tdata  = head_s[DATA_WIDTH-1:0];
  assign m_axis_tlast  = m_axis_tvalid & head_s[DATA_WIDTH];
  assign pop_s         = m_axis_tvalid & m_axis_tready;
  assign fifo_clr_s    = (state_r == IDLE) & start;
  // The returning word is the final beat when its pointer was the last one issued.
  assign push_last_s   = (inflight_ptr_r == (len_r - LEN_WIDTH'(1)));

  // Read issue: only while data remains, port A is free and the buffer can absorb it.
  always_comb begin
    rd_en_s = 1'b0;
    if ((state_r == RUN) && (issue_cnt_r < len_r) && !wr_busy) begin
      rd_en_s = has_room(count_s, inflight_r, pop_s);
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Control FSM with issue counter and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      len_r          <= {LEN_WIDTH{1'b0}};
      issue_cnt_r    <= {LEN_WIDTH{1'b0}};
      inflight_ptr_r <= {LEN_WIDTH{1'b0}};
      inflight_r     <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
      if (rd_en_s) begin
        inflight_ptr_r <= issue_cnt_r;
        issue_cnt_r    <= issue_cnt_r + LEN_WIDTH'(1);
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r       <= length;
            issue_cnt_r <= {LEN_WIDTH{1'b0}};
            inflight_r  <= 1'b0;
            state_r     <= (length != {LEN_WIDTH{1'b0}}) ? RUN : DONE;
          end
        end
        RUN: begin
          if (pop_s && head_s[DATA_WIDTH]) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy             = (state_r != IDLE);
  assign done             = (state_r == DONE);
  assign dma_rd_en        = rd_en_s;
  assign dma_read_pointer = DMA_PTR_WIDTH'(issue_cnt_r);

  stream_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr_s),
    .push      (inflight_r),
    .push_data ({push_last_s, dma_rd_data}),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a 1-cycle-latency BRAM model.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] length;
  logic        wr_busy;
  logic        busy;
  logic        done;
  logic        dma_rd_en;
  logic [15:0] dma_read_pointer;
  logic [31:0] dma_rd_data = 32'h0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  logic [31:0] bram [16];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dma_rd_en) dma_rd_data <= bram[dma_read_pointer[3:0]];
  end

  bram_stream_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .length           (length),
    .wr_busy          (wr_busy),
    .busy             (busy),
    .done             (done),
    .dma_rd_en        (dma_rd_en),
    .dma_read_pointer (dma_read_pointer),
    .dma_rd_data      (dma_rd_data),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 16; i++) bram[i] = base + 32'(i);
  endtask

  // Runs a transfer whose start was driven in the current cycle, scoreboarding every beat.
  task automatic drain(input string tag, input int len, input int mode, input int pause_at,
                       input int abort_at, input int repulse_len,
                       output int beats, output int dones);
    int issued = 0;
    int pause_left = 0;
    logic stalled = 1'b0;
    logic [31:0] held = 32'h0;
    logic finished = 1'b0;
    beats = 0;
    dones = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      start = (repulse_len != 0) && (cyc == 1);
      if (start) length = 16'(repulse_len);
      m_axis_tready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      wr_busy = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      #1;
      if (stalled) begin
        chk({tag, " hold_valid"}, 32'(m_axis_tvalid), 32'd1);
        chk({tag, " hold_data"}, m_axis_tdata, held);
      end
      if (wr_busy) chk({tag, " paused_rd_en"}, 32'(dma_rd_en), 32'd0);
      if (dma_rd_en) begin
        chk({tag, " ptr"}, 32'(dma_read_pointer), 32'(issued));
        issued++;
        if (issued == pause_at) pause_left = 3;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk({tag, " data"}, m_axis_tdata, bram[beats]);
        chk({tag, " last"}, 32'(m_axis_tlast), 32'(beats == len - 1));
        beats++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      if (done) begin
        dones++;
        finished = 1'b1;
        break;
      end
      if (abort_at != 0 && beats == abort_at) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    wr_busy = 1'b0;
    if (!finished) chk({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int beats;
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    length = 16'd0;
    wr_busy = 1'b0;
    m_axis_tready = 1'b0;
    fill(32'hA000_0000);
    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rd_en", 32'(dma_rd_en), 32'd0);
    chk("rst ptr", 32'(dma_read_pointer), 32'd0);
    chk("rst tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst tdata", m_axis_tdata, 32'd0);
    chk("rst tlast", 32'(m_axis_tlast), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Length 4 with a cycle-exact expectation table.
    start = 1'b1;
    length = 16'd4;
    m_axis_tready = 1'b1;
    #1;
    chk("t1 c0 busy", 32'(busy), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      #1;
      chk($sformatf("t1 c%0d busy", c), 32'(busy), 32'(c <= 7));
      chk($sformatf("t1 c%0d done", c), 32'(done), 32'(c == 7));
      chk($sformatf("t1 c%0d rd_en", c), 32'(dma_rd_en), 32'(c >= 1 && c <= 4));
      if (c <= 4) chk($sformatf("t1 c%0d ptr", c), 32'(dma_read_pointer), 32'(c - 1));
      chk($sformatf("t1 c%0d tvalid", c), 32'(m_axis_tvalid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("t1 c%0d tdata", c), m_axis_tdata, 32'hA000_0000 + 32'(c - 3));
      chk($sformatf("t1 c%0d tlast", c), 32'(m_axis_tlast), 32'(c == 6));
    end

    // Length 8 under a 1,0,0,1 ready pattern.
    fill(32'hB000_0000);
    tick();
    start = 1'b1;
    length = 16'd8;
    drain("t2", 8, 1, 0, 0, 0, beats, dones);
    chk("t2 beats", 32'(beats), 32'd8);
    chk("t2 done", 32'(dones), 32'd1);
    tick();

    // Zero length: done next cycle, no reads, no beats.
    tick();
    start = 1'b1;
    length = 16'd0;
    m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("t3 done", 32'(done), 32'd1);
    chk("t3 rd_en", 32'(dma_rd_en), 32'd0);
    chk("t3 tvalid", 32'(m_axis_tvalid), 32'd0);
    tick();
    chk("t3 idle busy", 32'(busy), 32'd0);
    chk("t3 idle done", 32'(done), 32'd0);

    // Length 6 with wr_busy for 3 cycles after the second issue.
    fill(32'hC000_0000);
    start = 1'b1;
    length = 16'd6;
    drain("t4", 6, 0, 2, 0, 0, beats, dones);
    chk("t4 beats", 32'(beats), 32'd6);
    chk("t4 done", 32'(dones), 32'd1);
    tick();

    // Reset after 2 beats of a 5-word transfer, then a fresh 2-word transfer.
    fill(32'hD000_0000);
    start = 1'b1;
    length = 16'd5;
    drain("t5a", 5, 0, 0, 2, 0, beats, dones);
    chk("t5a beats", 32'(beats), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t5 rst ptr", 32'(dma_read_pointer), 32'd0);
    chk("t5 rst done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5 no done", 32'(done), 32'd0);
      chk("t5 no tvalid", 32'(m_axis_tvalid), 32'd0);
    end
    fill(32'hE000_0000);
    start = 1'b1;
    length = 16'd2;
    drain("t5b", 2, 0, 0, 0, 0, beats, dones);
    chk("t5b beats", 32'(beats), 32'd2);
    chk("t5b done", 32'(dones), 32'd1);
    tick();

    // Start re-pulsed with a different length while busy is ignored.
    fill(32'hF000_0000);
    start = 1'b1;
    length = 16'd3;
    drain("t6", 3, 0, 0, 0, 7, beats, dones);
    chk("t6 beats", 32'(beats), 32'd3);
    chk("t6 done", 32'(dones), 32'd1);
    tick();
    chk("t6 idle busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side DMA engine that drains a block of words out of the DMA port of the shared BRAM and presents them as an AXI-Stream master. It sits between the BRAM wrapper (read pointer/data on port A) and the outbound stream interface. It is the counterpart of the slave-stream write FSM. It absorbs the fixed 1-cycle BRAM read latency and downstream backpressure with a 2-entry output buffer, and sustains one beat per cycle when `m_axis_tready` stays high.

## Interface
- `DATA_WIDTH`, 32, BRAM word and stream data width
- `LEN_WIDTH`, 16, width of transfer length and read pointer
- `clk` in 1: single clock for all logic
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request; honoured only in IDLE
- `length` in LEN_WIDTH: number of words; latched on accepted `start`
- `wr_busy` in 1: write FSM owns BRAM port A; blocks read issue
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse at transfer end
- `dma_rd_en` out 1: read issued this cycle
- `dma_read_pointer` out 16: word offset of the current read, relative to base
- `dma_rd_data` in DATA_WIDTH: BRAM port A read data
- `m_axis_tdata` out DATA_WIDTH: stream data
- `m_axis_tvalid` out 1: stream valid
- `m_axis_tready` in 1: stream ready
- `m_axis_tlast` out 1: final beat marker

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start` with `length` != 0. Latch `length`, clear the issue and beat counters, and clear the buffer.
- IDLE → DONE on `start` with `length` == 0. No reads and no beats occur.
- RUN → DONE on the handshake (`tvalid & tready`) of beat index `length`-1.
- DONE → IDLE unconditionally.
- A read is issued (`dma_rd_en`=1) when all of the following hold:
  - state is RUN;
  - issued < length;
  - `wr_busy`=0;
  - (buffer count + reads in flight − pop this cycle) < 2.
- `dma_read_pointer` equals the issue counter and increments after each issue. It holds its value when no read is issued.
- An in-flight flag is registered from `dma_rd_en`. When the flag is set, `dma_rd_data` is written into the buffer at the end of that cycle.
- `m_axis_tvalid` = buffer non-empty. `m_axis_tdata` = buffer head.
- `m_axis_tlast` = valid AND head is beat index `length`-1.
- `tdata` and `tlast` are held stable while `tvalid`=1 and `tready`=0.
- Counters are LEN_WIDTH wide and have no wrap in normal operation, because `length` ≤ 2^LEN_WIDTH−1.
- `start` outside IDLE is ignored.
- `wr_busy` rising mid-transfer only pauses issue. An in-flight read still completes.
- Reset at any time returns to IDLE, empties the buffer, clears the in-flight flag, and aborts without a `done` pulse.

## Timing
- Reset value of all outputs: 0 (`busy`, `done`, `dma_rd_en`, `dma_read_pointer`, `m_axis_tdata`, `m_axis_tvalid`, `m_axis_tlast`).
- BRAM read latency is fixed at 1: data for the pointer presented in cycle t is valid on `dma_rd_data` in cycle t+1.
- With `start` in cycle 0:
  - cycle 1: RUN, first `dma_rd_en` with pointer 0;
  - cycle 2: data captured;
  - cycle 3: first `m_axis_tvalid`.
- Throughput is 1 beat/cycle with `tready` held high. An N-word transfer has its last handshake in cycle N+2 and `done` in cycle N+3.
- `done` is asserted in the DONE cycle. `busy` falls in the cycle after `done`.
- Backpressure: at most 2 words are buffered plus in flight, so no BRAM word is dropped or reread.

## Structure
- Shared package `tpu_dma_pkg` holds:
  - `rd_state_t` enum (IDLE, RUN, DONE);
  - `BRAM_RD_LATENCY` = 1;
  - the DMA pointer width constant (16).
- Sub-module `stream_skid_fifo`: 2-entry, DATA_WIDTH+1 bits (data, last), with push/pop/count ports. Instantiated once.

## Test plan
- `length`=4, BRAM[0..3]=A0..A3, `tready`=1 → beats A0..A3 in cycles 3–6, `tlast` only on A3, `done` in cycle 7, pointers 0,1,2,3 in cycles 1–4.
- `length`=8, `tready` toggled 1,0,0,1 repeating → all 8 words in order with no duplicates, `tdata` stable during stalls, `dma_read_pointer` never exceeds 7.
- `length`=0 → `done` one cycle after `start`; no `dma_rd_en`; no `tvalid`.
- `length`=6 with `wr_busy`=1 for 3 cycles after the second issue → issue pauses, stream resumes in order, and 6 beats total complete.
- `rst_n` asserted mid-transfer after 2 beats, then `start` with `length`=2 → the first transfer is aborted with no `done`; the new transfer begins at pointer 0 and delivers exactly 2 beats.
- `start` re-pulsed while `busy` → ignored; the original length completes unchanged.
